// File: rtl/ace_snoop_ctrl_if.sv
// ---------------------------------------------------------------------------
// ace_snoop_ctrl_if
// Bundle of ACE snoop channel (AC/CR/CD), cache-array arbitration and
// datapath lookup signals around ace_snoop_ctrl.
//   slave  : the snoop controller side (ace_snoop_ctrl)
//   master : the environment side (interconnect, cache controller, datapath)
// Signals:
//   AC_VALID/AC_READY/ac_invalidate             snoop address channel
//   CR_VALID/CR_READY/cr_data_transfer/cr_pass_dirty  snoop response channel
//   CD_VALID/CD_READY/CD_LAST/cd_beat           snoop data channel
//   core_req/core_gnt/snoop_gnt                 tag/data array ownership
//   lookup_done/snoop_hit/snoop_dirty           datapath tag lookup result
//   invalidate_en                               invalidate snooped line
// ---------------------------------------------------------------------------
interface ace_snoop_ctrl_if #(
  parameter int CD_BEATS = 4,
  parameter int BEAT_W   = $clog2(CD_BEATS)
);
  logic              AC_VALID;
  logic              AC_READY;
  logic              ac_invalidate;
  logic              CR_VALID;
  logic              CR_READY;
  logic              cr_data_transfer;
  logic              cr_pass_dirty;
  logic              CD_VALID;
  logic              CD_READY;
  logic              CD_LAST;
  logic [BEAT_W-1:0] cd_beat;
  logic              core_req;
  logic              core_gnt;
  logic              snoop_gnt;
  logic              lookup_done;
  logic              snoop_hit;
  logic              snoop_dirty;
  logic              invalidate_en;

  modport slave (
    input  AC_VALID, ac_invalidate, CR_READY, CD_READY, core_req,
           lookup_done, snoop_hit, snoop_dirty,
    output AC_READY, CR_VALID, cr_data_transfer, cr_pass_dirty, CD_VALID,
           CD_LAST, cd_beat, core_gnt, snoop_gnt, invalidate_en
  );

  modport master (
    output AC_VALID, ac_invalidate, CR_READY, CD_READY, core_req,
           lookup_done, snoop_hit, snoop_dirty,
    input  AC_READY, CR_VALID, cr_data_transfer, cr_pass_dirty, CD_VALID,
           CD_LAST, cd_beat, core_gnt, snoop_gnt, invalidate_en
  );
endinterface

// File: rtl/ace_snoop_ctrl.sv
// ---------------------------------------------------------------------------
// ace_snoop_ctrl
// Sequences one ACE snoop (AC -> tag lookup -> CR -> optional CD line) and
// arbitrates the shared cache tag/data arrays between the snoop path and the
// cache controller. Snoops normally win the arrays; after a snoop finishes
// while the core is waiting, the core gets the next turn (core_turn).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ace_snoop_ctrl_if.slave (AC/CR/CD channels, core_req/core_gnt,
//          snoop_gnt, lookup result, invalidate_en, cd_beat)
// ---------------------------------------------------------------------------
module ace_snoop_ctrl #(
  parameter int CD_BEATS = 4,
  parameter int BEAT_W   = $clog2(CD_BEATS)
) (
  input  logic               clk,
  input  logic               rst_n,
  ace_snoop_ctrl_if.slave    bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_DATA   = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

  logic [1:0]        state_q, state_d;
  logic              core_gnt_q, core_gnt_d;
  logic              core_turn_q, core_turn_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              inv_q, inv_d;
  logic              hit_q, hit_d;
  logic              dirty_q, dirty_d;
  logic              inv_pulse_q, inv_pulse_d;

  logic              in_idle;
  logic              ac_hs;
  logic              data_xfer;
  logic              last_beat;
  logic              snoop_done;

  assign in_idle   = (state_q == ST_IDLE);
  // Core owns the arrays, or it is the core's turn and it is asking: hold AC off.
  assign bus.AC_READY = in_idle && !core_gnt_q && !(core_turn_q && bus.core_req);
  assign ac_hs     = bus.AC_VALID && bus.AC_READY;
  assign data_xfer = hit_q && dirty_q;
  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    inv_d       = inv_q;
    hit_d       = hit_q;
    dirty_d     = dirty_q;
    inv_pulse_d = 1'b0;
    snoop_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ac_hs) begin
          inv_d   = bus.ac_invalidate;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (bus.lookup_done) begin
          hit_d       = bus.snoop_hit;
          dirty_d     = bus.snoop_dirty;
          // Registered so the pulse lands in the cycle after lookup_done.
          inv_pulse_d = inv_q && bus.snoop_hit;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.CR_READY) begin
          if (data_xfer) begin
            state_d = ST_DATA;
          end else begin
            state_d    = ST_IDLE;
            snoop_done = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bus.CD_READY) begin
          if (last_beat) begin
            beat_d     = '0;
            state_d    = ST_IDLE;
            snoop_done = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant only from IDLE when no snoop is taken this cycle; once granted,
    // hold until the core drops its request.
    core_gnt_d = bus.core_req && (core_gnt_q || (in_idle && !ac_hs));

    core_turn_d = core_turn_q;
    if (core_gnt_d && !core_gnt_q) begin
      core_turn_d = 1'b0;
    end else if (snoop_done && bus.core_req) begin
      core_turn_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      core_gnt_q  <= 1'b0;
      core_turn_q <= 1'b0;
      beat_q      <= '0;
      inv_q       <= 1'b0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      inv_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_gnt_q  <= core_gnt_d;
      core_turn_q <= core_turn_d;
      beat_q      <= beat_d;
      inv_q       <= inv_d;
      hit_q       <= hit_d;
      dirty_q     <= dirty_d;
      inv_pulse_q <= inv_pulse_d;
    end
  end

  assign bus.core_gnt         = core_gnt_q;
  assign bus.snoop_gnt        = !in_idle;
  assign bus.CR_VALID         = (state_q == ST_RESP);
  assign bus.cr_data_transfer = (state_q == ST_RESP) && data_xfer;
  assign bus.cr_pass_dirty    = (state_q == ST_RESP) && data_xfer;
  assign bus.CD_VALID         = (state_q == ST_DATA);
  assign bus.CD_LAST          = (state_q == ST_DATA) && last_beat;
  assign bus.cd_beat          = beat_q;
  assign bus.invalidate_en    = inv_pulse_q;

endmodule

// File: tb/tb_ace_snoop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ace_snoop_ctrl
// Self-checking bench for ace_snoop_ctrl. Inputs are driven just after the
// rising edge, outputs are sampled on the falling edge. Expected values come
// from transaction-level rules: lookup latency, response bits from hit/dirty,
// beat sequence with stalls, and the core/snoop turn-taking rules.
// ---------------------------------------------------------------------------
module tb_ace_snoop_ctrl;
  localparam int CD_BEATS = 4;
  localparam int BEAT_W   = $clog2(CD_BEATS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  ace_snoop_ctrl_if #(.CD_BEATS(CD_BEATS)) bus ();

  ace_snoop_ctrl #(.CD_BEATS(CD_BEATS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.AC_VALID      = 1'b0;
    bus.ac_invalidate = 1'b0;
    bus.CR_READY      = 1'b0;
    bus.CD_READY      = 1'b0;
    bus.core_req      = 1'b0;
    bus.lookup_done   = 1'b0;
    bus.snoop_hit     = 1'b0;
    bus.snoop_dirty   = 1'b0;
  endtask

  // Stimulus only: completes a snoop currently in LOOKUP as a clean miss.
  task automatic finish_miss_snoop();
    bus.lookup_done = 1'b1;
    bus.snoop_hit   = 1'b0;
    tick();
    bus.lookup_done = 1'b0;
    bus.CR_READY    = 1'b1;
    tick();
    bus.CR_READY    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      vec_cnt++;
      if ({bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty, bus.CD_VALID, bus.CD_LAST,
           bus.cd_beat, bus.core_gnt, bus.snoop_gnt, bus.invalidate_en} !== '0) begin
        err_cnt++;
        $display("FAIL reset_outputs: got %b required all zero",
                 {bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty, bus.CD_VALID, bus.CD_LAST,
                  bus.cd_beat, bus.core_gnt, bus.snoop_gnt, bus.invalidate_en});
      end
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    vec_cnt++;
    if ({bus.AC_READY, bus.core_gnt, bus.snoop_gnt, bus.CR_VALID, bus.CD_VALID} !== 5'b10000) begin
      err_cnt++;
      $display("FAIL reset_release: got %b required 10000",
               {bus.AC_READY, bus.core_gnt, bus.snoop_gnt, bus.CR_VALID, bus.CD_VALID});
    end
    tick();
    $display("txn reset: done");
  endtask

  task automatic test_clean_miss();
    bus.AC_VALID      = 1'b1;
    bus.ac_invalidate = 1'($urandom_range(0, 1));
    @(negedge clk);
    vec_cnt++;
    if (bus.AC_READY !== 1'b1) begin
      err_cnt++;
      $display("FAIL miss_accept: AC_READY got %b required 1", bus.AC_READY);
    end
    tick();
    bus.AC_VALID    = 1'b0;
    bus.lookup_done = 1'b1;
    bus.snoop_hit   = 1'b0;
    bus.snoop_dirty = 1'($urandom_range(0, 1));
    @(negedge clk);
    vec_cnt++;
    if ({bus.snoop_gnt, bus.AC_READY, bus.CR_VALID} !== 3'b100) begin
      err_cnt++;
      $display("FAIL miss_lookup: got %b required 100", {bus.snoop_gnt, bus.AC_READY, bus.CR_VALID});
    end
    tick();
    bus.lookup_done = 1'b0;
    bus.CR_READY    = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty, bus.invalidate_en} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL miss_resp: got %b required 1000",
               {bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty, bus.invalidate_en});
    end
    tick();
    bus.CR_READY = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.CR_VALID, bus.CD_VALID, bus.snoop_gnt, bus.AC_READY} !== 4'b0001) begin
      err_cnt++;
      $display("FAIL miss_idle: got %b required 0001",
               {bus.CR_VALID, bus.CD_VALID, bus.snoop_gnt, bus.AC_READY});
    end
    tick();
    $display("txn clean_miss: done");
  endtask

  task automatic test_random_snoops(input int n);
    int  stalls[CD_BEATS];
    bit  inv, hit, dirty, dt, exp_inv;
    int  ld, crd, total;
    for (int t = 0; t < n; t++) begin
      inv   = 1'($urandom_range(0, 1));
      hit   = 1'($urandom_range(0, 1));
      dirty = 1'($urandom_range(0, 1));
      ld    = int'($urandom_range(0, 3));
      crd   = int'($urandom_range(0, 2));
      for (int b = 0; b < CD_BEATS; b++) stalls[b] = int'($urandom_range(0, 3));
      if (t == 0) begin
        // dirty hit with invalidate, no stalls
        inv = 1'b1; hit = 1'b1; dirty = 1'b1; ld = 0; crd = 0;
        for (int b = 0; b < CD_BEATS; b++) stalls[b] = 0;
      end else if (t == 1) begin
        // backpressure: beats 1 and 2 each stalled 3 cycles -> 10-cycle line
        inv = 1'b0; hit = 1'b1; dirty = 1'b1; ld = 0; crd = 0;
        for (int b = 0; b < CD_BEATS; b++) stalls[b] = (b == 1 || b == 2) ? 3 : 0;
      end
      dt      = hit && dirty;
      exp_inv = inv && hit;
      total   = 0;

      bus.AC_VALID      = 1'b1;
      bus.ac_invalidate = inv;
      @(negedge clk);
      vec_cnt++;
      if (bus.AC_READY !== 1'b1) begin
        err_cnt++;
        $display("FAIL rnd_accept[%0d]: AC_READY got %b required 1", t, bus.AC_READY);
      end
      tick();
      bus.AC_VALID      = 1'b0;
      bus.ac_invalidate = 1'($urandom_range(0, 1));

      for (int k = 0; k <= ld; k++) begin
        bus.lookup_done = (k == ld);
        bus.snoop_hit   = (k == ld) ? hit   : 1'($urandom_range(0, 1));
        bus.snoop_dirty = (k == ld) ? dirty : 1'($urandom_range(0, 1));
        bus.CR_READY    = 1'($urandom_range(0, 1));
        bus.CD_READY    = 1'($urandom_range(0, 1));
        @(negedge clk);
        vec_cnt++;
        if ({bus.snoop_gnt, bus.CR_VALID, bus.CD_VALID, bus.invalidate_en, bus.AC_READY} !== 5'b10000) begin
          err_cnt++;
          $display("FAIL rnd_lookup[%0d]: got %b required 10000", t,
                   {bus.snoop_gnt, bus.CR_VALID, bus.CD_VALID, bus.invalidate_en, bus.AC_READY});
        end
        tick();
      end
      bus.lookup_done = 1'b0;

      for (int k = 0; k <= crd; k++) begin
        bus.CR_READY    = (k == crd);
        bus.lookup_done = 1'($urandom_range(0, 1));
        bus.snoop_hit   = 1'($urandom_range(0, 1));
        bus.snoop_dirty = 1'($urandom_range(0, 1));
        bus.CD_READY    = 1'($urandom_range(0, 1));
        @(negedge clk);
        vec_cnt++;
        if ({bus.snoop_gnt, bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty, bus.CD_VALID,
             bus.invalidate_en} !== {1'b1, 1'b1, dt, dt, 1'b0, (k == 0) && exp_inv}) begin
          err_cnt++;
          $display("FAIL rnd_resp[%0d]: got %b required %b", t,
                   {bus.snoop_gnt, bus.CR_VALID, bus.cr_data_transfer, bus.cr_pass_dirty,
                    bus.CD_VALID, bus.invalidate_en},
                   {1'b1, 1'b1, dt, dt, 1'b0, (k == 0) && exp_inv});
        end
        tick();
      end
      bus.CR_READY = 1'b0;

      if (dt) begin
        for (int b = 0; b < CD_BEATS; b++) begin
          for (int s = 0; s <= stalls[b]; s++) begin
            bus.CD_READY    = (s == stalls[b]);
            bus.lookup_done = 1'($urandom_range(0, 1));
            bus.CR_READY    = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            vec_cnt++;
            if ({bus.CD_VALID, bus.CD_LAST, bus.cd_beat, bus.CR_VALID, bus.invalidate_en, bus.snoop_gnt}
                !== {1'b1, 1'(b == CD_BEATS - 1), BEAT_W'(b), 1'b0, 1'b0, 1'b1}) begin
              err_cnt++;
              $display("FAIL rnd_data[%0d] beat %0d: got %b required %b", t, b,
                       {bus.CD_VALID, bus.CD_LAST, bus.cd_beat, bus.CR_VALID, bus.invalidate_en,
                        bus.snoop_gnt},
                       {1'b1, 1'(b == CD_BEATS - 1), BEAT_W'(b), 1'b0, 1'b0, 1'b1});
            end
            tick();
          end
        end
      end

      clear_inputs();
      @(negedge clk);
      vec_cnt++;
      if ({bus.CD_VALID, bus.CR_VALID, bus.snoop_gnt, bus.invalidate_en, bus.AC_READY} !== 5'b00001) begin
        err_cnt++;
        $display("FAIL rnd_idle[%0d]: got %b required 00001", t,
                 {bus.CD_VALID, bus.CR_VALID, bus.snoop_gnt, bus.invalidate_en, bus.AC_READY});
      end
      tick();
      $display("txn snoop %0d: inv=%0b hit=%0b dirty=%0b lookup_wait=%0d cr_wait=%0d data_cycles=%0d",
               t, inv, hit, dirty, ld, crd, total);
    end
  endtask

  task automatic test_simultaneous();
    bus.AC_VALID = 1'b1;
    bus.core_req = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.AC_READY, bus.core_gnt} !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul_snoop_wins: got %b required 10", {bus.AC_READY, bus.core_gnt});
    end
    tick();
    bus.AC_VALID    = 1'b0;
    bus.lookup_done = 1'b1;
    bus.snoop_hit   = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.snoop_gnt, bus.core_gnt} !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul_lookup: got %b required 10", {bus.snoop_gnt, bus.core_gnt});
    end
    tick();
    bus.lookup_done = 1'b0;
    bus.CR_READY    = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.CR_VALID, bus.core_gnt} !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul_resp: got %b required 10", {bus.CR_VALID, bus.core_gnt});
    end
    tick();
    bus.CR_READY = 1'b0;
    bus.AC_VALID = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.snoop_gnt, bus.core_gnt, bus.AC_READY} !== 3'b000) begin
      err_cnt++;
      $display("FAIL simul_core_turn: got %b required 000", {bus.snoop_gnt, bus.core_gnt, bus.AC_READY});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({bus.core_gnt, bus.snoop_gnt, bus.AC_READY} !== 3'b100) begin
        err_cnt++;
        $display("FAIL simul_core_gnt[%0d]: got %b required 100", i,
                 {bus.core_gnt, bus.snoop_gnt, bus.AC_READY});
      end
      tick();
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.core_gnt, bus.AC_READY} !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul_release: got %b required 10", {bus.core_gnt, bus.AC_READY});
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if ({bus.core_gnt, bus.AC_READY} !== 2'b01) begin
      err_cnt++;
      $display("FAIL simul_second_accept: got %b required 01", {bus.core_gnt, bus.AC_READY});
    end
    tick();
    bus.AC_VALID = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.snoop_gnt, bus.core_gnt} !== 2'b10) begin
      err_cnt++;
      $display("FAIL simul_second_lookup: got %b required 10", {bus.snoop_gnt, bus.core_gnt});
    end
    finish_miss_snoop();
    $display("txn simultaneous: done");
  endtask

  task automatic test_core_hold();
    bus.core_req = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.core_gnt, bus.AC_READY} !== 2'b01) begin
      err_cnt++;
      $display("FAIL hold_pre_grant: got %b required 01", {bus.core_gnt, bus.AC_READY});
    end
    tick();
    bus.AC_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec_cnt++;
      if ({bus.core_gnt, bus.AC_READY, bus.snoop_gnt} !== 3'b100) begin
        err_cnt++;
        $display("FAIL hold_cycle[%0d]: got %b required 100", i,
                 {bus.core_gnt, bus.AC_READY, bus.snoop_gnt});
      end
      tick();
    end
    bus.core_req = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.core_gnt, bus.AC_READY} !== 2'b10) begin
      err_cnt++;
      $display("FAIL hold_drop: got %b required 10", {bus.core_gnt, bus.AC_READY});
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if ({bus.core_gnt, bus.AC_READY} !== 2'b01) begin
      err_cnt++;
      $display("FAIL hold_accept: got %b required 01", {bus.core_gnt, bus.AC_READY});
    end
    tick();
    bus.AC_VALID = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.snoop_gnt, bus.core_gnt} !== 2'b10) begin
      err_cnt++;
      $display("FAIL hold_lookup: got %b required 10", {bus.snoop_gnt, bus.core_gnt});
    end
    finish_miss_snoop();
    $display("txn core_hold: done");
  endtask

  task automatic test_reset_in_data();
    bus.AC_VALID = 1'b1;
    tick();
    bus.AC_VALID    = 1'b0;
    bus.lookup_done = 1'b1;
    bus.snoop_hit   = 1'b1;
    bus.snoop_dirty = 1'b1;
    tick();
    bus.lookup_done = 1'b0;
    bus.CR_READY    = 1'b1;
    tick();
    bus.CR_READY = 1'b0;
    bus.CD_READY = 1'b1;
    tick();
    bus.CD_READY = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({bus.CD_VALID, bus.cd_beat} !== {1'b1, BEAT_W'(1)}) begin
      err_cnt++;
      $display("FAIL rstdata_beat1: got %b required %b", {bus.CD_VALID, bus.cd_beat}, {1'b1, BEAT_W'(1)});
    end
    #1;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({bus.CD_VALID, bus.CD_LAST, bus.cd_beat, bus.snoop_gnt, bus.CR_VALID, bus.core_gnt} !== '0) begin
      err_cnt++;
      $display("FAIL rstdata_abort: got %b required all zero",
               {bus.CD_VALID, bus.CD_LAST, bus.cd_beat, bus.snoop_gnt, bus.CR_VALID, bus.core_gnt});
    end
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({bus.AC_READY, bus.CD_VALID, bus.snoop_gnt} !== 3'b100) begin
      err_cnt++;
      $display("FAIL rstdata_release: got %b required 100", {bus.AC_READY, bus.CD_VALID, bus.snoop_gnt});
    end
    tick();
    $display("txn reset_in_data: done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_clean_miss();
    test_random_snoops(40);
    test_simultaneous();
    test_core_hold();
    test_reset_in_data();
    test_clean_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
